// File: rtl/noise_shaper_quant.sv
// First-order error-feedback requantizer: signed I.F sample -> NB-bit offset-binary level code,
// with the fractional residual fed back into the next sample and optional LFSR dither.
module noise_shaper_quant #(
    parameter int I  = 16,
    parameter int F  = 16,
    parameter int NB = 4,
    parameter int CW = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [I+F-1:0]    data_i,
    input  logic              valid_i,
    input  logic              dither_en_i,
    input  logic              ovl_clr_i,
    output logic [NB-1:0]     code_o,
    output logic              valid_o,
    output logic              ovl_o,
    output logic [CW-1:0]     ovl_cnt_o
);

    localparam int W = I + F;

    localparam logic signed [I-1:0]  QMAX_I = {{(I-NB+1){1'b0}}, {(NB-1){1'b1}}};
    localparam logic signed [I-1:0]  QMIN_I = ~QMAX_I;
    localparam logic signed [W:0]    RMAX   = {{(W+1-F){1'b0}}, {F{1'b1}}};
    localparam logic signed [W:0]    RMIN   = ~RMAX;
    localparam logic signed [W-1:0]  DPOS   = {{(W-F+1){1'b0}}, 1'b1, {(F-2){1'b0}}};
    localparam logic signed [W-1:0]  DNEG   = -DPOS;
    localparam logic [NB-1:0]        MID    = {1'b1, {(NB-1){1'b0}}};
    localparam logic [15:0]          LFSR_SEED = 16'hACE1;

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W-1:0] s;
        s = a + b;
        if (!a[W-1] && !b[W-1] && s[W-1])
            return {1'b0, {(W-1){1'b1}}};
        if (a[W-1] && b[W-1] && !s[W-1])
            return {1'b1, {(W-1){1'b0}}};
        return s;
    endfunction

    function automatic logic signed [NB-1:0] clamp_q(input logic signed [I-1:0] qf);
        if (qf > QMAX_I)
            return QMAX_I[NB-1:0];
        if (qf < QMIN_I)
            return QMIN_I[NB-1:0];
        return qf[NB-1:0];
    endfunction

    // Residual is limited to +/-1 code step so an overload burst recovers within a sample.
    function automatic logic signed [W-1:0] clamp_r(input logic signed [W:0] e);
        if (e > RMAX)
            return RMAX[W-1:0];
        if (e < RMIN)
            return RMIN[W-1:0];
        return e[W-1:0];
    endfunction

    logic signed [W-1:0]  r_p0;
    logic [15:0]          lfsr_p0;
    logic [NB-1:0]        code_p1;
    logic                 vld_p1;
    logic                 ovl_p1;
    logic [CW-1:0]        ovl_cnt_p1;

    logic signed [W-1:0]  v0_c;
    logic signed [W-1:0]  v_c;
    logic signed [I-1:0]  qf_c;
    logic signed [NB-1:0] q_c;
    logic                 ovl_c;
    logic signed [W:0]    qsh_c;
    logic signed [W:0]    e_c;
    logic signed [W-1:0]  r_next_c;
    logic                 lfsr_fb_c;

    always_comb begin
        v0_c      = sat_add(data_i, r_p0);
        v_c       = dither_en_i ? sat_add(v0_c, lfsr_p0[0] ? DPOS : DNEG) : v0_c;
        qf_c      = v_c[W-1:F];
        q_c       = clamp_q(qf_c);
        ovl_c     = (qf_c > QMAX_I) || (qf_c < QMIN_I);
        qsh_c     = {{(W+1-NB-F){q_c[NB-1]}}, q_c, {F{1'b0}}};
        e_c       = {v_c[W-1], v_c} - qsh_c;
        r_next_c  = clamp_r(e_c);
        lfsr_fb_c = lfsr_p0[0] ^ lfsr_p0[2] ^ lfsr_p0[3] ^ lfsr_p0[5];
    end

    // ---- stage p0 -> p1: quantized code, residual and dither state registered ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            code_p1    <= MID;
            vld_p1     <= 1'b0;
            ovl_p1     <= 1'b0;
            ovl_cnt_p1 <= '0;
            r_p0       <= '0;
            lfsr_p0    <= LFSR_SEED;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                code_p1 <= q_c ^ MID;
                ovl_p1  <= ovl_c;
                r_p0    <= r_next_c;
                lfsr_p0 <= {lfsr_fb_c, lfsr_p0[15:1]};
            end
            if (ovl_clr_i)
                ovl_cnt_p1 <= '0;
            else if (valid_i && ovl_c && (ovl_cnt_p1 != {CW{1'b1}}))
                ovl_cnt_p1 <= ovl_cnt_p1 + 1'b1;
        end
    end

    assign code_o    = code_p1;
    assign valid_o   = vld_p1;
    assign ovl_o     = ovl_p1;
    assign ovl_cnt_o = ovl_cnt_p1;

endmodule

// File: tb/tb_noise_shaper_quant.sv
// Self-checking bench for noise_shaper_quant (I=16, F=16, NB=4, CW=8) against an integer
// reference model of the requantizer.
module tb_noise_shaper_quant;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        valid;
    logic        dither_en;
    logic        ovl_clr;
    logic [3:0]  code;
    logic        vout;
    logic        ovl;
    logic [7:0]  ovl_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint   m_r;
    bit [15:0] m_lfsr;
    int       m_code;
    bit       m_ovl;
    int       m_cnt;
    bit       m_vld;

    noise_shaper_quant #(.I(16), .F(16), .NB(4), .CW(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .valid_i     (valid),
        .dither_en_i (dither_en),
        .ovl_clr_i   (ovl_clr),
        .code_o      (code),
        .valid_o     (vout),
        .ovl_o       (ovl),
        .ovl_cnt_o   (ovl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sat32(input longint s);
        if (s > 64'sd2147483647)  return 64'sd2147483647;
        if (s < -64'sd2147483648) return -64'sd2147483648;
        return s;
    endfunction

    task automatic model_reset();
        m_r = 0; m_lfsr = 16'hACE1; m_code = 8; m_ovl = 0; m_cnt = 0; m_vld = 0;
    endtask

    task automatic model_step(input logic [31:0] d, input bit de, input bit clr);
        longint v, qf, q, e;
        int taps[4];
        bit fb;
        taps = '{16, 14, 13, 11};
        v = sat32(longint'($signed(d)) + m_r);
        if (de) v = sat32(v + (m_lfsr[0] ? 64'sd16384 : -64'sd16384));
        qf = v >>> 16;
        q = (qf > 7) ? 7 : ((qf < -8) ? -8 : qf);
        m_ovl = (q != qf);
        e = v - q * 65536;
        m_r = (e > 65535) ? 65535 : ((e < -65536) ? -65536 : e);
        m_code = int'(q) + 8;
        fb = 1'b0;
        for (int k = 0; k < 4; k++) fb ^= m_lfsr[16 - taps[k]];
        m_lfsr = {fb, m_lfsr[15:1]};
        if (clr) m_cnt = 0;
        else if (m_ovl && m_cnt < 255) m_cnt++;
    endtask

    task automatic cycle(input logic [31:0] d, input logic vi, input logic de, input logic clr);
        data = d; valid = vi; dither_en = de; ovl_clr = clr;
        @(posedge clk); #1;
        if (vi) model_step(d, de, clr);
        else if (clr) m_cnt = 0;
        m_vld = vi;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1);
        for (int k = 0; k < 5; k++) cycle(32'h000A_0000, 1, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle(32'h000A_0000, 1, 1, 0);
            checks++;
            if (code !== 4'd8 || vout !== 1'b0 || ovl !== 1'b0 || ovl_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset: code=%0d valid=%b ovl=%b cnt=%0d, want 8/0/0/0",
                         code, vout, ovl, ovl_cnt);
            end
        end
        rst = 1'b0;
        model_reset();
        cycle(32'h0000_4000, 1, 0, 0);
        checks++;
        if (code !== 4'd8 || vout !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_sample: code=%0d valid=%b, want 8/1", code, vout);
        end
    endtask

    task automatic test_quarter();
        int exp_codes[8];
        exp_codes = '{8, 8, 8, 9, 8, 8, 8, 9};
        do_reset(1);
        cycle(32'h0, 0, 0, 0);
        checks++;
        if (vout !== 1'b0) begin
            errors++;
            $display("FAIL quarter_idle_valid: got %b want 0", vout);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(32'h0000_4000, 1, 0, 0);
            checks++;
            if (code !== 4'(exp_codes[k]) || vout !== 1'b1 || code !== 4'(m_code)) begin
                errors++;
                $display("FAIL quarter[%0d]: code=%0d valid=%b, want %0d/1", k, code, vout,
                         exp_codes[k]);
            end
        end
        cycle(32'h0, 0, 0, 0);
        checks++;
        if (vout !== 1'b0) begin
            errors++;
            $display("FAIL quarter_valid_drop: got %b want 0", vout);
        end
    endtask

    task automatic test_neg_half();
        int exp_codes[6];
        exp_codes = '{7, 8, 7, 8, 7, 8};
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            cycle(32'hFFFF_8000, 1, 0, 0);
            checks++;
            if (code !== 4'(exp_codes[k]) || ovl !== 1'b0) begin
                errors++;
                $display("FAIL neg_half[%0d]: code=%0d ovl=%b, want %0d/0", k, code, ovl,
                         exp_codes[k]);
            end
        end
    endtask

    task automatic test_overload();
        do_reset(1);
        for (int k = 1; k <= 300; k++) begin
            cycle(32'h000A_0000, 1, 0, 0);
            checks++;
            if (code !== 4'd15 || ovl !== 1'b1 || ovl_cnt !== 8'((k > 255) ? 255 : k)) begin
                errors++;
                $display("FAIL overload[%0d]: code=%0d ovl=%b cnt=%0d, want 15/1/%0d", k, code,
                         ovl, ovl_cnt, (k > 255) ? 255 : k);
            end
        end
        cycle(32'h000A_0000, 1, 0, 1);
        checks++;
        if (ovl_cnt !== 8'd0 || ovl !== 1'b1) begin
            errors++;
            $display("FAIL overload_clear: cnt=%0d ovl=%b, want 0/1", ovl_cnt, ovl);
        end
        // residual should now be exactly 0xFFFF: one more LSB reaches the next code
        cycle(32'h0000_0001, 1, 0, 0);
        checks++;
        if (code !== 4'd9 || ovl !== 1'b0 || ovl_cnt !== 8'd0) begin
            errors++;
            $display("FAIL overload_residual: code=%0d ovl=%b cnt=%0d, want 9/0/0", code, ovl,
                     ovl_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset(1);
        for (int k = 0; k < 3; k++) cycle(32'h0000_4000, 1, 0, 0);
        cycle(32'h7FFF_FFFF, 1, 0, 0);
        checks++;
        if (code !== 4'd15 || ovl !== 1'b1) begin
            errors++;
            $display("FAIL saturation: code=%0d ovl=%b, want 15/1", code, ovl);
        end
        cycle(32'h0000_0001, 1, 0, 0);
        checks++;
        if (code !== 4'd9 || code !== 4'(m_code)) begin
            errors++;
            $display("FAIL saturation_recover: code=%0d want 9", code);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] prev;
        do_reset(1);
        for (int k = 0; k < 16; k++) begin
            prev = code;
            cycle(32'h0000_4000, (k % 4) == 0 || (k % 4) == 3, 1'(k / 8), 0);
            checks++;
            if (code !== 4'(m_code) || vout !== m_vld ||
                (!m_vld && code !== prev)) begin
                errors++;
                $display("FAIL gaps[%0d]: code=%0d valid=%b, want %0d/%b", k, code, vout,
                         m_code, m_vld);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        do_reset(1);
        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'($signed($urandom_range(0, 20 * 65536)) - 10 * 65536);
                default: d = 32'($signed($urandom_range(0, 4 * 65536)) - 2 * 65536);
            endcase
            cycle(d, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0));
            checks++;
            if (code !== 4'(m_code) || vout !== m_vld || ovl !== m_ovl ||
                ovl_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL random[%0d]: code=%0d v=%b ovl=%b cnt=%0d, want %0d/%b/%b/%0d", k,
                         code, vout, ovl, ovl_cnt, m_code, m_vld, m_ovl, m_cnt);
            end
        end
    endtask

    task automatic test_dither_mean();
        int sum;
        int bad;
        sum = 0;
        bad = 0;
        do_reset(1);
        for (int k = 0; k < 1024; k++) begin
            cycle(32'h0, 1, 1, 0);
            sum += int'(code);
            if (code !== 4'(m_code)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dither_model: %0d samples differ from model, want 0", bad);
        end
        checks++;
        if (sum < 8192 - 51 || sum > 8192 + 51) begin
            errors++;
            $display("FAIL dither_mean: code sum=%0d over 1024, want 8192 +/- 51", sum);
        end
    endtask

    initial begin
        rst = 1'b1; data = '0; valid = 1'b0; dither_en = 1'b0; ovl_clr = 1'b0;
        model_reset();
        test_reset();
        test_quarter();
        test_neg_half();
        test_overload();
        test_saturation();
        test_gaps();
        test_random();
        test_dither_mean();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
